// File: rtl/fw_scoreboard.sv
// fw_scoreboard: D-stage hazard/forwarding scoreboard with shadow writer pipeline and MDU busy countdown
module fw_scoreboard #(
    parameter int NSRC = 2,
    parameter int DEPTH = 3,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    localparam int SELW = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic                 D_valid,
    input  logic                 D_wen,
    input  logic [4:0]           D_wreg,
    input  logic [1:0]           D_wdst,
    input  logic [1:0]           D_tnew,
    input  logic [5*NSRC-1:0]    D_rreg,
    input  logic [2*NSRC-1:0]    D_tuse,
    input  logic                 D_uses_mdu,
    input  logic                 mdu_start,
    input  logic                 mdu_is_div,
    output logic                 stall,
    output logic [SELW*NSRC-1:0] fw_sel,
    output logic [NSRC-1:0]      fw_dst2,
    output logic                 mdu_busy
);
    localparam int MAXL = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CW = $clog2(MAXL + 1);

    logic [DEPTH-1:0] e_valid;
    logic [DEPTH-1:0] e_wen;
    logic [4:0]       e_wreg [DEPTH];
    logic [1:0]       e_wdst [DEPTH];
    logic [1:0]       e_tnew [DEPTH];
    logic [CW-1:0]    cnt;
    logic [NSRC-1:0]  src_stall;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        logic [4:0]      rreg;
        logic [1:0]      tuse;
        logic            hit;
        logic [1:0]      mt;
        logic [1:0]      mw;
        logic [SELW-1:0] sel;
        assign rreg = D_rreg[5*g +: 5];
        assign tuse = D_tuse[2*g +: 2];
        // nearest matching writer wins: scan oldest to youngest so entry 0 overrides
        always_comb begin
            hit = 1'b0;
            mt = 2'd0;
            mw = 2'd0;
            sel = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (e_valid[k] && e_wen[k] && e_wreg[k] != 5'd0 && e_wreg[k] == rreg) begin
                    hit = 1'b1;
                    mt = e_tnew[k];
                    mw = e_wdst[k];
                    sel = SELW'(k + 1);
                end
            end
        end
        assign src_stall[g] = hit && (mt > tuse);
        assign fw_sel[SELW*g +: SELW] = (hit && mt == 2'd0) ? sel : '0;
        assign fw_dst2[g] = hit && mt == 2'd0 && mw == 2'd2;
    end

    assign mdu_busy = (cnt != '0) || mdu_start;
    assign stall = D_valid && ((|src_stall) || (D_uses_mdu && mdu_busy));

    // shadow pipeline: age and shift writers unless frozen; stalled D becomes a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid <= '0;
            e_wen <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                e_wreg[k] <= 5'd0;
                e_wdst[k] <= 2'd0;
                e_tnew[k] <= 2'd0;
            end
        end else if (!hold) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                e_valid[k] <= e_valid[k-1];
                e_wen[k] <= e_wen[k-1];
                e_wreg[k] <= e_wreg[k-1];
                e_wdst[k] <= e_wdst[k-1];
                e_tnew[k] <= (e_tnew[k-1] != 2'd0) ? e_tnew[k-1] - 2'd1 : 2'd0;
            end
            e_valid[0] <= D_valid && !stall;
            e_wen[0] <= D_wen;
            e_wreg[0] <= D_wreg;
            e_wdst[0] <= D_wdst;
            e_tnew[0] <= D_tnew;
        end
    end

    // MDU busy countdown keeps running through hold; a new start reloads it
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (mdu_start)
            cnt <= mdu_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end
endmodule

// File: tb/tb_fw_scoreboard.sv
// tb_fw_scoreboard: directed and randomized checks of fw_scoreboard against a queue-based writer model
module tb_fw_scoreboard;
    localparam int NSRC = 2;
    localparam int DEPTH = 3;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    typedef struct {
        logic       valid;
        logic       wen;
        logic [4:0] wreg;
        logic [1:0] wdst;
        int         tnew0;
        int         age;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic hold = 1'b0;
    logic D_valid = 1'b0;
    logic D_wen = 1'b0;
    logic [4:0] D_wreg = '0;
    logic [1:0] D_wdst = '0;
    logic [1:0] D_tnew = '0;
    logic [9:0] D_rreg = '0;
    logic [3:0] D_tuse = '0;
    logic D_uses_mdu = 1'b0;
    logic mdu_start = 1'b0;
    logic mdu_is_div = 1'b0;
    logic stall;
    logic [3:0] fw_sel;
    logic [1:0] fw_dst2;
    logic mdu_busy;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int busy_until = -1;
    ent_t q[$];

    fw_scoreboard #(.NSRC(NSRC), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .hold(hold), .D_valid(D_valid), .D_wen(D_wen),
        .D_wreg(D_wreg), .D_wdst(D_wdst), .D_tnew(D_tnew), .D_rreg(D_rreg), .D_tuse(D_tuse),
        .D_uses_mdu(D_uses_mdu), .mdu_start(mdu_start), .mdu_is_div(mdu_is_div),
        .stall(stall), .fw_sel(fw_sel), .fw_dst2(fw_dst2), .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    // q[k] is the writer k stages past D; its remaining latency is its issue tnew minus stages travelled
    function automatic void model_eval(output logic st, output logic [3:0] sel,
                                       output logic [1:0] d2, output logic mb);
        logic any;
        logic [4:0] r;
        int tu;
        int t;
        bit found;
        any = 1'b0;
        sel = '0;
        d2 = '0;
        mb = mdu_start || (cyc <= busy_until);
        for (int s = 0; s < NSRC; s++) begin
            r = D_rreg[5*s +: 5];
            tu = int'(D_tuse[2*s +: 2]);
            found = 0;
            for (int k = 0; k < q.size(); k++) begin
                if (!found && q[k].valid && q[k].wen && q[k].wreg != 0 && q[k].wreg == r) begin
                    found = 1;
                    t = q[k].tnew0 - q[k].age;
                    if (t < 0) t = 0;
                    if (t > tu) any = 1'b1;
                    if (t == 0) begin
                        sel[2*s +: 2] = 2'(k + 1);
                        d2[s] = (q[k].wdst == 2'd2);
                    end
                end
            end
        end
        st = D_valid && (any || (D_uses_mdu && mb));
    endfunction

    task automatic model_reset();
        q.delete();
        busy_until = -1;
    endtask

    task automatic model_update();
        logic st;
        logic [3:0] sl;
        logic [1:0] d;
        logic mb;
        ent_t e;
        if (reset) begin
            model_reset();
        end else begin
            model_eval(st, sl, d, mb);
            if (!hold) begin
                foreach (q[k]) q[k].age++;
                e.valid = D_valid && !st;
                e.wen = D_wen;
                e.wreg = D_wreg;
                e.wdst = D_wdst;
                e.tnew0 = int'(D_tnew);
                e.age = 0;
                q.push_front(e);
                if (q.size() > DEPTH) void'(q.pop_back());
            end
            if (mdu_start) busy_until = cyc + (mdu_is_div ? DIV_LAT : MUL_LAT);
        end
        cyc++;
    endtask

    // every cycle, outputs are compared against the model on the falling edge
    always @(negedge clk) begin
        logic est;
        logic [3:0] esel;
        logic [1:0] ed2;
        logic emb;
        model_eval(est, esel, ed2, emb);
        nvec++;
        if (stall !== est) begin nerr++; $display("FAIL stall: got %b want %b at %0t", stall, est, $time); end
        if (fw_sel !== esel) begin nerr++; $display("FAIL fw_sel: got %h want %h at %0t", fw_sel, esel, $time); end
        if (fw_dst2 !== ed2) begin nerr++; $display("FAIL fw_dst2: got %b want %b at %0t", fw_dst2, ed2, $time); end
        if (mdu_busy !== emb) begin nerr++; $display("FAIL mdu_busy: got %b want %b at %0t", mdu_busy, emb, $time); end
    end

    task automatic chk(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        hold = 1'b0;
        D_valid = 1'b0;
        D_wen = 1'b0;
        D_wreg = '0;
        D_wdst = '0;
        D_tnew = '0;
        D_rreg = '0;
        D_tuse = '0;
        D_uses_mdu = 1'b0;
        mdu_start = 1'b0;
        mdu_is_div = 1'b0;
    endtask

    task automatic wr(input logic [4:0] r, input logic [1:0] t, input logic [1:0] w);
        idle();
        D_valid = 1'b1;
        D_wen = 1'b1;
        D_wreg = r;
        D_tnew = t;
        D_wdst = w;
    endtask

    task automatic rd(input int s, input logic [4:0] r, input logic [1:0] tu);
        D_valid = 1'b1;
        D_rreg[5*s +: 5] = r;
        D_tuse[2*s +: 2] = tu;
    endtask

    task automatic flush();
        idle();
        repeat (DEPTH) tick();
    endtask

    initial begin
        idle();
        repeat (2) tick();
        reset = 1'b0;
        tick();

        wr(8, 2, 2);
        #3 chk("lu_issue_stall", stall, 0);
        tick();
        idle(); rd(0, 8, 0);
        #3 chk("lu_stall1", stall, 1);
        tick();
        #3 chk("lu_stall2", stall, 1);
        tick();
        #3 chk("lu_release", stall, 0);
        chk("lu_fwsel", fw_sel[1:0], 3);
        chk("lu_dst2", fw_dst2[0], 1);
        tick();

        flush();
        wr(8, 2, 2);
        tick();
        idle(); rd(0, 8, 1);
        #3 chk("lu1_stall", stall, 1);
        tick();
        #3 chk("lu1_release", stall, 0);
        chk("lu1_fwsel", fw_sel[1:0], 0);
        tick();

        flush();
        wr(3, 1, 0);
        tick();
        idle(); rd(1, 3, 1);
        #3 chk("alu_stall", stall, 0);
        chk("alu_fwsel1", fw_sel[3:2], 0);
        tick();
        idle(); rd(0, 3, 0);
        #3 chk("alu_fwsel0", fw_sel[1:0], 2);
        chk("alu_dst2", fw_dst2[0], 0);
        chk("alu_stall2", stall, 0);
        tick();

        flush();
        wr(5, 1, 0);
        tick();
        wr(5, 1, 0);
        tick();
        idle(); rd(0, 5, 0);
        #3 chk("prio_stall", stall, 1);
        chk("prio_fwsel", fw_sel, 0);
        tick();

        flush();
        wr(0, 3, 2);
        tick();
        wr(7, 3, 2); D_wen = 1'b0;
        tick();
        idle(); rd(0, 0, 0); rd(1, 7, 0);
        #3 chk("null_stall", stall, 0);
        chk("null_fwsel", fw_sel, 0);
        tick();

        flush();
        wr(9, 2, 0);
        tick();
        idle(); rd(0, 9, 0); hold = 1'b1;
        repeat (4) begin
            #3 chk("hold_stall", stall, 1);
            chk("hold_fwsel", fw_sel, 0);
            tick();
        end
        hold = 1'b0;
        #3 chk("unhold_stall1", stall, 1);
        tick();
        #3 chk("unhold_stall2", stall, 1);
        tick();
        #3 chk("unhold_release", stall, 0);
        chk("unhold_fwsel", fw_sel[1:0], 3);
        tick();

        flush();
        mdu_start = 1'b1; mdu_is_div = 1'b1;
        #3 chk("div_start_busy", mdu_busy, 1);
        tick();
        idle(); D_valid = 1'b1; D_uses_mdu = 1'b1;
        repeat (DIV_LAT) begin
            #3 chk("div_stall", stall, 1);
            tick();
        end
        #3 chk("div_release", stall, 0);
        chk("div_idle", mdu_busy, 0);
        tick();

        idle(); mdu_start = 1'b1;
        tick();
        idle(); D_valid = 1'b1; D_uses_mdu = 1'b1;
        repeat (MUL_LAT) begin
            #3 chk("mul_stall", stall, 1);
            tick();
        end
        #3 chk("mul_release", stall, 0);
        tick();

        idle(); mdu_start = 1'b1;
        tick();
        idle(); D_valid = 1'b1;
        #3 chk("nonmdu_stall", stall, 0);
        chk("nonmdu_busy", mdu_busy, 1);
        tick();

        flush();
        wr(8, 2, 0);
        tick();
        wr(9, 1, 0); mdu_start = 1'b1;
        tick();
        idle(); rd(0, 8, 0); D_uses_mdu = 1'b1;
        #1 chk("pre_reset_stall", stall, 1);
        reset = 1'b1;
        model_reset();
        #1 chk("rst_stall", stall, 0);
        chk("rst_fwsel", fw_sel, 0);
        chk("rst_busy", mdu_busy, 0);
        tick();
        reset = 1'b0;
        idle();
        tick();
        rd(0, 8, 0);
        #3 chk("post_rst_fwsel", fw_sel, 0);
        chk("post_rst_stall", stall, 0);
        tick();

        for (int i = 0; i < 3000; i++) begin
            D_valid = $urandom_range(0, 7) != 0;
            D_wen = $urandom_range(0, 3) != 0;
            D_wreg = 5'($urandom_range(0, 7));
            D_wdst = 2'($urandom);
            D_tnew = 2'($urandom);
            D_rreg = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            D_tuse = 4'($urandom);
            D_uses_mdu = $urandom_range(0, 3) == 0;
            mdu_start = $urandom_range(0, 11) == 0;
            mdu_is_div = $urandom_range(0, 1) == 1;
            hold = $urandom_range(0, 7) == 0;
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                mdu_start = 1'b0;
                model_reset();
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/fw_scoreboard.md
Name: fw_scoreboard

Overview:
- Parametrised hazard and forwarding scoreboard for the pipelined MIPS core, sitting at the consumer (D) stage.
- Tracks every in-flight GRF writer in a DEPTH-entry shadow pipeline (E, M, W, ...) and ages each writer's tnew as it advances.
- Per source operand, generates forwarding selects and a stall request.
- Adds an MDU busy countdown, so mult/div consumers stall without external logic.

Parameters:
NSRC, 2, number of source operands checked per cycle
DEPTH, 3, tracked stages downstream of consumer (entry 0 = E, entry DEPTH-1 = last)
MUL_LAT, 5, MDU busy cycles for mult
DIV_LAT, 10, MDU busy cycles for div
(derived) SELW = clog2(DEPTH+1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
hold  in  1  global freeze: no entry advances, no tnew ageing
D_valid  in  1  D holds a real instruction
D_wen  in  1  D instruction writes GRF
D_wreg  in  5  D destination register
D_wdst  in  2  D write-data source code
D_tnew  in  2  cycles until D result ready, measured at entry 0
D_rreg  in  5*NSRC  source registers, packed
D_tuse  in  2*NSRC  per-source tuse, packed
D_uses_mdu  in  1  D reads/writes HI/LO or starts MDU
mdu_start  in  1  MDU operation starts this cycle (from E)
mdu_is_div  in  1  selects DIV_LAT else MUL_LAT
stall  out  1  freeze D/F, bubble into entry 0
fw_sel  out  SELW*NSRC  0 = GRF; k = entry k-1
fw_dst2  out  NSRC  matched entry's wdst == 2
mdu_busy  out  1  counter nonzero or mdu_start

Behaviour:
- Reset (async): all entries invalid, tnew 0, MDU counter 0. Outputs stall=0, fw_sel=0, fw_dst2=0, mdu_busy=0.
- Entry fields:
  - valid, wen, wreg, wdst, tnew.
  - An entry matches source s iff valid && wen && wreg != 0 && wreg == rreg_s.
- Per source s (combinational):
  - Take the nearest match, lowest index k.
  - If tnew_k > tuse_s, src_stall_s=1.
  - If tnew_k == 0, fw_sel_s = k+1 and fw_dst2_s = (wdst_k == 2).
  - Otherwise fw_sel_s = 0 and fw_dst2_s = 0.
  - Older matching entries are ignored, even if their tnew is 0.
  - No match: fw_sel_s = 0, no stall.
  - rreg = 0 never stalls or forwards.
- Stall:
  - stall = D_valid && (OR of src_stall_s || (D_uses_mdu && mdu_busy)).
  - Stall does not depend on hold.
- Clock edge, hold=1: entries unchanged; the MDU counter still counts.
- Clock edge, hold=0:
  - Entry k+1 <= entry k, with tnew decremented and saturating at 0.
  - The last entry drops out.
  - Entry 0 <= D fields with tnew = D_tnew if D_valid && !stall; otherwise entry 0 becomes an invalid bubble.
- MDU counter:
  - mdu_start loads MUL_LAT or DIV_LAT, per mdu_is_div.
  - Otherwise it decrements when nonzero, and saturates at 0.
  - mdu_busy = (count != 0) || mdu_start.
  - mdu_start while busy reloads the counter.
- Reset asserted mid-operation clears all state immediately; outputs fall to reset values in the same cycle.

Test Plan:
- Reset: assert reset mid-stream with entries full -> stall=0, fw_sel=0, mdu_busy=0 immediately; the first post-reset reader of r8 sees fw_sel=0.
- Load-use: issue wen, wreg=8, tnew=2, wdst=2; next cycle D rreg0=8, tuse0=0 -> stall=1 for exactly 2 cycles.
  - Cycle 3: fw_sel0=3, fw_dst2[0]=1, stall=0.
  - Same sequence with tuse0=1 -> stall for 1 cycle only.
- ALU chain: issue wreg=3, tnew=1, wdst=0; next cycle D rreg1=3, tuse1=1 -> stall=0, fw_sel1=0.
  - One cycle later, a reader of r3 with tuse=0 -> fw_sel=2, fw_dst2=0.
- Priority: entry 0 holds wreg=5, tnew=1; entry 1 holds wreg=5, tnew=0; reader of r5 with tuse=0 -> stall=1 and fw_sel=0 (entry 1 not used).
- Null writers: wreg=0, or wen=0 with wreg=7 -> readers of r0/r7 never stall and always get fw_sel=0.
- Hold: with hold=1 for 4 cycles, entries freeze and stall/fw_sel stay constant; on release, ageing resumes from the frozen tnew values.
- MDU: mdu_start with mdu_is_div=1 (DIV_LAT=10), D_uses_mdu=1 -> stall=1 for 10 cycles, released on cycle 11.
  - mdu_start with mdu_is_div=0 -> 5 stall cycles.
  - A non-MDU reader during busy -> stall=0.
